// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Purpose  : Shared types and the address-window helper for the bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_bus_addr_width = 5;
    localparam int c_bus_data_width = 4;

    // Window bounds are 32 bits wide so an exclusive end can sit one past the
    // top of any address space narrower than 32 bits.
    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_range_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } bridge_state_e;

    typedef struct packed {
        logic                        r_wn;
        logic [c_bus_addr_width-1:0] addr;
        logic [c_bus_data_width-1:0] wdata;
    } cmd_t;

    function automatic logic addr_in_ranges(input logic [31:0] a, input addr_range_t r);
        return (a >= r.start_addr) && (a < r.end_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_cmd_fifo
// Purpose  : Command FIFO with wrap-bit pointers; pushes are refused when full.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cmd_fifo
    import bus_pkg::*;
#(
    parameter type T          = cmd_t,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  T                              push_data,
    input  logic                          pop,
    output T                              pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_one   = (c_ptr_w + 1)'(1);

    logic [c_ptr_w:0] r_wr_ptr;
    logic [c_ptr_w:0] r_rd_ptr;
    T                 r_mem [FIFO_DEPTH];
    logic             w_push;
    logic             w_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign count    = r_wr_ptr - r_rd_ptr;
    assign full     = (count == c_depth);
    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ptr_w-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : bus_cmd_bridge
// Purpose  : Turns a valid/ready command stream into native bus cycles and
//            returns one response per command; misses never reach the bus.
// Revision : 1.0 - initial release
// ============================================================================
module bus_cmd_bridge
    import bus_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 5,
    parameter int          DATA_WIDTH   = 4,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          RD_LATENCY   = 1,
    parameter int          NUM_RANGES   = 2,
    parameter addr_range_t VALID_RANGES [NUM_RANGES] = '{'{32'd0, 32'd4}, '{32'd16, 32'd24}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_r_wn,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  r_wn,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    typedef struct packed {
        logic                  r_wn;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } bridge_cmd_t;

    localparam int              c_cnt_w      = $clog2(RD_LATENCY + 1);
    localparam int              c_fifo_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_rd  = c_cnt_w'(RD_LATENCY);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle  = ST_IDLE;
    localparam logic [1:0] c_st_drive = ST_DRIVE;
    localparam logic [1:0] c_st_resp  = ST_RESP;

    logic [1:0]              r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_bus_r_wn;
    logic [ADDR_WIDTH-1:0]   r_bus_addr;
    logic [DATA_WIDTH-1:0]   r_bus_wdata;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    bridge_cmd_t             w_push_cmd;
    bridge_cmd_t             w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_hit;
    logic [NUM_RANGES-1:0]   w_win_hit;
    logic [c_fifo_cnt_w-1:0] w_count;

    assign w_push_cmd = {cmd_r_wn, cmd_addr, cmd_wdata};
    assign w_pop      = (r_state == c_st_idle) && !w_empty;

    bus_cmd_fifo #(
        .T          (bridge_cmd_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    for (genvar g = 0; g < NUM_RANGES; g++) begin : g_win
        assign w_win_hit[g] = addr_in_ranges(32'(w_head.addr), VALID_RANGES[g]);
    end
    assign w_hit = |w_win_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_bus_r_wn  <= 1'b1;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (!w_empty) begin
                        if (w_hit) begin
                            r_bus_r_wn  <= w_head.r_wn;
                            r_bus_addr  <= w_head.addr;
                            r_bus_wdata <= w_head.wdata;
                            r_cnt       <= w_head.r_wn ? c_cnt_rd : c_cnt_one;
                            r_state     <= c_st_drive;
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= c_st_resp;
                        end
                    end
                end
                c_st_drive: begin
                    if (r_cnt == c_cnt_one) begin
                        r_rsp_rdata <= r_bus_r_wn ? rdata : '0;
                        r_rsp_err   <= 1'b0;
                        r_bus_r_wn  <= 1'b1;
                        r_bus_addr  <= '0;
                        r_bus_wdata <= '0;
                        r_state     <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign cmd_ready = !w_full;
    assign rsp_valid = (r_state == c_st_resp);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign r_wn      = r_bus_r_wn;
    assign addr      = r_bus_addr;
    assign wdata     = r_bus_wdata;
    assign busy      = (w_count != '0) || (r_state != c_st_idle);

endmodule
`default_nettype wire
